// File: rtl/switch_arb_pkg.sv
// switch_arbiter shared types: direction codes, output state, round-robin pick.
// Aging is compiled in with SWITCH_ARBITER_AGING_EN.
package switch_arb_pkg;

    localparam int DIR_X     = 0;
    localparam int DIR_Y     = 1;
    localparam int DIR_LOCAL = 2;
    localparam int DIR_NONE  = 3;

    localparam int MAX_IN = 16;
    localparam int IW     = 4;

    typedef enum logic {
        IDLE,
        LOCKED
    } out_st_e;

    // Bits above the real input count must be zero; the wrap then needs no size.
    function automatic logic [IW-1:0] rr_pick(
        input logic [MAX_IN-1:0] req,
        input logic [IW-1:0]     ptr
    );
        logic [IW-1:0] hi;
        logic [IW-1:0] lo;
        logic          fh;
        hi = '0;
        lo = '0;
        fh = 1'b0;
        for (int k = MAX_IN - 1; k >= 0; k--) begin
            if (req[k]) begin
                lo = IW'(k);
                if (k >= int'(ptr)) begin
                    hi = IW'(k);
                    fh = 1'b1;
                end
            end
        end
        return fh ? hi : lo;
    endfunction

endpackage

// File: rtl/switch_arbiter_if.sv
// Request/grant bundle between input buffers, arbiter and crossbar select.
// The arbiter takes the slave side.
interface switch_arbiter_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 4,
    parameter int DW    = $clog2(N_OUT)
);
    logic [N_IN-1:0]    req_valid;
    logic [N_IN*DW-1:0] req_dst;
    logic [N_IN-1:0]    req_last;
    logic [N_OUT-1:0]   out_ready;
    logic [N_IN-1:0]    grant;
    logic [N_IN-1:0]    fail;
    logic [N_OUT-1:0]   out_lock;
    logic [N_IN-1:0]    starve;

    modport master (
        output req_valid, req_dst, req_last, out_ready,
        input  grant, fail, out_lock, starve
    );

    modport slave (
        input  req_valid, req_dst, req_last, out_ready,
        output grant, fail, out_lock, starve
    );
endinterface

// File: rtl/switch_arbiter_rr_out_arb.sv
// One output port: IDLE/LOCKED state, owner, round-robin pointer, one-hot grant.
// Starved requesters (all-zero without SWITCH_ARBITER_AGING_EN) win in IDLE.
module rr_out_arb
    import switch_arb_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] req_i,
    input  logic [N_IN-1:0] last_i,
    input  logic [N_IN-1:0] starve_i,
    input  logic            ready_i,
    output logic [N_IN-1:0] gnt_o,
    output logic            lock_o
);
    localparam int PW = (N_IN > 1) ? $clog2(N_IN) : 1;

    out_st_e         st_q;
    logic [PW-1:0]   owner_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win;
    logic            has;
    logic [N_IN-1:0] aged;

    always_comb begin
        aged  = req_i & starve_i;
        win   = '0;
        has   = 1'b0;
        gnt_o = '0;
        if (st_q == LOCKED) begin
            win = owner_q;
            has = req_i[owner_q];
        end else if (|aged) begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (aged[i]) win = PW'(i);
            end
            has = 1'b1;
        end else if (|req_i) begin
            win = PW'(rr_pick(MAX_IN'(req_i), IW'(ptr_q)));
            has = 1'b1;
        end
        if (has && ready_i) gnt_o[win] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            st_q    <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else if (|gnt_o) begin
            if (last_i[win]) begin
                st_q  <= IDLE;
                ptr_q <= (win == PW'(N_IN - 1)) ? '0 : win + 1'b1;
            end else begin
                st_q    <= LOCKED;
                owner_q <= win;
            end
        end
    end

    assign lock_o = (st_q == LOCKED);

endmodule

// File: rtl/switch_arbiter.sv
// Per-output round-robin crossbar arbiter with packet locking.
// Define SWITCH_ARBITER_AGING_EN to add per-input wait counters and starve priority.
module switch_arbiter
    import switch_arb_pkg::*;
#(
    parameter int N_IN     = 3,
    parameter int N_OUT    = 4,
    parameter int DW       = $clog2(N_OUT),
    parameter int MAX_WAIT = 7
) (
    input logic              clk,
    input logic              rst_n,
    switch_arbiter_if.slave  bus
);
    logic [N_IN-1:0]  req_m [N_OUT];
    logic [N_IN-1:0]  gnt_m [N_OUT];
    logic [N_OUT-1:0] lock_w;
    logic [N_IN-1:0]  grant_w;
    logic [N_IN-1:0]  starve_w;

    // Out-of-range destinations match no output, so they can only fail.
    always_comb begin
        for (int o = 0; o < N_OUT; o++) begin
            for (int i = 0; i < N_IN; i++) begin
                req_m[o][i] = bus.req_valid[i]
                    && (bus.req_dst[i*DW +: DW] == DW'(o));
            end
        end
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        rr_out_arb #(
            .N_IN(N_IN)
        ) u_arb (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_i    (req_m[o]),
            .last_i   (bus.req_last),
            .starve_i (starve_w),
            .ready_i  (bus.out_ready[o]),
            .gnt_o    (gnt_m[o]),
            .lock_o   (lock_w[o])
        );
    end

    always_comb begin
        grant_w = '0;
        for (int o = 0; o < N_OUT; o++) begin
            grant_w = grant_w | gnt_m[o];
        end
    end

`ifdef SWITCH_ARBITER_AGING_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q [N_IN];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (!bus.req_valid[i] || grant_w[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] != CW'(MAX_WAIT)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            starve_w[i] = (cnt_q[i] == CW'(MAX_WAIT));
        end
    end
`else
    assign starve_w = '0;
`endif

    assign bus.grant    = rst_n ? '0 : grant_w;
    assign bus.fail     = rst_n ? '0 : (bus.req_valid & ~grant_w);
    assign bus.out_lock = lock_w;
    assign bus.starve   = starve_w;

endmodule

// File: doc/switch_arbiter.md
# switch_arbiter

- Parametrised output-port arbiter for the router crossbar, replacing the fixed 3-input conflict judge.
- Each input channel presents a valid, a destination and a tail flag. The block grants each output to at most one input per cycle using per-output round-robin priority.
- An output stays locked to one input until that input's packet tail transfers.
- It sits between the input buffers and the crossbar mux select logic, and reports per-input grant and fail.

## Interface
- `N_IN`, default 3: number of input channels (X, Y, LOCAL in the base router).
- `N_OUT`, default 4: number of output directions.
- `DW`, default `$clog2(N_OUT)`: destination field width.
- `MAX_WAIT`, default 7: aging threshold in cycles (only used with aging compiled in).
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-high.
- `req_valid`, input, `N_IN`: input i has a flit to send.
- `req_dst`, input, `N_IN*DW`: destination of input i, in slice `[i*DW +: DW]`.
- `req_last`, input, `N_IN`: flit of input i is a packet tail.
- `out_ready`, input, `N_OUT`: output o can accept a flit this cycle.
- `grant`, output, `N_IN`: input i transfers this cycle.
- `fail`, output, `N_IN`: input i is valid but not granted.
- `out_lock`, output, `N_OUT`: output o is held by an unfinished packet (registered).
- `starve`, output, `N_IN`: input i has reached aged priority (registered).

## Operation
- A request from i to o exists when `req_valid[i]` is 1 and `req_dst[i] == o`.
- A request with `req_dst >= N_OUT` is illegal: it is never granted, and `fail[i]=1`.
- Per-output state is IDLE or LOCKED(owner), plus a round-robin pointer `ptr[o]` in the range 0..N_IN-1.
- **IDLE:** the winner is the first requester at or after `ptr[o]`, scanning upward with wrap.
  - The winner is granted only if `out_ready[o]` is 1.
  - If no output is ready, there is no grant and every requester fails.
- **LOCKED(owner):** only the owner can be granted, and only while `out_ready[o]` is 1. All other requesters to o fail.
- A transfer on o is a grant to i for o.
- On a transfer with `req_last=0`: the output goes to LOCKED(i), and `ptr` does not change.
- On a transfer with `req_last=1`: the output goes to IDLE, and `ptr[o] = (i+1) mod N_IN`.
- A single-flit packet (`req_last=1` on first grant) never locks.
- An input requests exactly one output per cycle, so `grant` is one-hot per output and at most one output per input.
- `fail = req_valid & ~grant`.
- A locked owner that deasserts valid keeps the lock; the output idles until the owner returns.

## Timing
- `grant` and `fail` are combinational from the inputs and the current state, with zero-cycle latency.
- `ptr`, the lock state and the aging counters update on the rising `clk` edge following a transfer.
- `out_lock` and `starve` are registered and reflect the state after the edge.
- Reset asserted (`rst_n=1`), effective immediately with no clock needed:
  - all `ptr` values go to 0, all outputs go to IDLE, and counters go to 0;
  - `grant=0`, `fail=0`, `out_lock=0` and `starve=0`, even while requests are present.
- Reset in the middle of a packet drops the lock. The next cycle after release arbitrates from `ptr=0`.
- When `out_ready[o]` is low there is no grant. State and `ptr` hold.
- When `N_IN=1`, `ptr` stays at 0.

## Configuration
- `SWITCH_ARBITER_AGING_EN` defined:
  - each input has a saturating wait counter of width `$clog2(MAX_WAIT+1)`;
  - the counter increments on every cycle with `fail[i]=1` and clears on grant or when valid is 0;
  - `starve[i] = (cnt[i] == MAX_WAIT)`.
  - In IDLE, starved requesters beat round-robin; among them the lowest index wins.
  - Aging never breaks a lock.
- Macro undefined: no counters are built, `starve` is tied to 0, and arbitration is pure round-robin.

## Structure
- Package `switch_arb_pkg` holds:
  - the direction encoding constants `DIR_X=0`, `DIR_Y=1`, `DIR_LOCAL=2`, `DIR_NONE=3`;
  - the output state enum `{IDLE, LOCKED}`;
  - a function `rr_pick(req, ptr)` returning the winner index.
- One sub-module, `rr_out_arb`, is instantiated `N_OUT` times. Each instance holds that output's state, owner and `ptr`, and produces a one-hot grant vector.
- The top level ORs the per-output grants into `grant`, and holds the aging counters.

## Test plan
1. Reset, then input 0 → dst 1 and input 1 → dst 1, with `ready=1`, all `last=1`. Over 4 cycles, grants alternate 0, 1, 0, 1, and `fail` is the complement.
2. Input 0 sends 3 flits to dst 2 (`last` on the third) while input 2 also requests dst 2. `out_lock[2]` is 1 for 2 cycles, input 2 fails for 3 cycles, then input 2 is granted on cycle 4.
3. Input 1 → dst 0 and input 2 → dst 3 in the same cycle. Both are granted, and `fail=0`.
4. `out_ready[1]=0` for 2 cycles with input 0 requesting. There is no grant, `fail[0]=1`, and `ptr` is unchanged. The grant arrives in the cycle ready rises.
5. Assert `rst_n` while output 2 is locked to input 0. `out_lock` and `grant` drop without a clock. After release, input 1 wins against input 0 only if it is the first from `ptr=0` (i.e. input 0 wins).
6. With the macro defined and `MAX_WAIT=3`: starve input 2 behind input 0's multi-flit packets. `starve[2]=1` after 3 fail cycles, and input 2 wins the next IDLE arbitration despite `ptr=0`. Without the macro, `starve` stays 0.
